// File: rtl/echo_indication_input.sv
// echo_indication_input: decodes tagged 96-bit pipe messages into "heard"
// indication calls through a two-entry ping-pong buffer. Messages whose tag
// is not HEARD_TAG are discarded and counted in a saturating drop counter.
module echo_indication_input #(
  parameter int unsigned HEARD_TAG = 1,
  parameter int unsigned DROP_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pipe_enq__ENA,
  input  logic [95:0]       pipe_enq_v,
  output logic              pipe_enq__RDY,
  output logic              indication_heard__ENA,
  output logic [31:0]       indication_heard_meth,
  output logic [31:0]       indication_heard_v,
  input  logic              indication_heard__RDY,
  output logic [DROP_W-1:0] drop_count
);

  logic [1:0]        full;
  logic [31:0]       meth_q [2];
  logic [31:0]       v_q    [2];
  logic              wsel;
  logic              rsel;
  logic [DROP_W-1:0] drop_q;

  logic enq_take;
  logic deq_take;
  logic tag_heard;

  always_comb begin
    pipe_enq__RDY         = ~full[wsel];
    indication_heard__ENA = full[rsel];
    indication_heard_meth = full[rsel] ? meth_q[rsel] : '0;
    indication_heard_v    = full[rsel] ? v_q[rsel]    : '0;
    drop_count            = drop_q;
    tag_heard             = (pipe_enq_v[31:0] == 32'(HEARD_TAG));
    enq_take              = pipe_enq__ENA & ~full[wsel];
    deq_take              = full[rsel] & indication_heard__RDY;
  end

  // Simultaneous enqueue and dequeue always touch different entries: the
  // write entry is empty while the read entry is full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      full      <= '0;
      meth_q[0] <= '0;
      meth_q[1] <= '0;
      v_q[0]    <= '0;
      v_q[1]    <= '0;
      wsel      <= 1'b0;
      rsel      <= 1'b0;
      drop_q    <= '0;
    end else begin
      if (enq_take && tag_heard) begin
        meth_q[wsel] <= pipe_enq_v[63:32];
        v_q[wsel]    <= pipe_enq_v[95:64];
        full[wsel]   <= 1'b1;
        wsel         <= ~wsel;
      end
      if (enq_take && !tag_heard && (drop_q != '1)) begin
        drop_q <= drop_q + DROP_W'(1);
      end
      if (deq_take) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
      end
    end
  end

endmodule

// File: tb/tb_echo_indication_input.sv
// Directed, table-driven bench for echo_indication_input.
module tb_echo_indication_input;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pipe_enq__ENA;
  logic [95:0] pipe_enq_v;
  logic        pipe_enq__RDY;
  logic        indication_heard__ENA;
  logic [31:0] indication_heard_meth;
  logic [31:0] indication_heard_v;
  logic        indication_heard__RDY;
  logic [15:0] drop_count;

  logic        s_ena;
  logic [95:0] s_msg;
  logic        s_rdy;
  logic        s_hena;
  logic [31:0] s_hmeth;
  logic [31:0] s_hv;
  logic [1:0]  s_drop;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  echo_indication_input #(.HEARD_TAG(1), .DROP_W(16)) dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .pipe_enq__ENA         (pipe_enq__ENA),
    .pipe_enq_v            (pipe_enq_v),
    .pipe_enq__RDY         (pipe_enq__RDY),
    .indication_heard__ENA (indication_heard__ENA),
    .indication_heard_meth (indication_heard_meth),
    .indication_heard_v    (indication_heard_v),
    .indication_heard__RDY (indication_heard__RDY),
    .drop_count            (drop_count)
  );

  echo_indication_input #(.HEARD_TAG(1), .DROP_W(2)) dut_sat (
    .CLK                   (CLK),
    .RST                   (RST),
    .pipe_enq__ENA         (s_ena),
    .pipe_enq_v            (s_msg),
    .pipe_enq__RDY         (s_rdy),
    .indication_heard__ENA (s_hena),
    .indication_heard_meth (s_hmeth),
    .indication_heard_v    (s_hv),
    .indication_heard__RDY (1'b1),
    .drop_count            (s_drop)
  );

  typedef struct {
    logic        rst;
    logic        enq;
    logic [31:0] tag;
    logic [31:0] meth;
    logic [31:0] v;
    logic        hrdy;
    logic        e_rdy;
    logic        e_ena;
    logic [31:0] e_meth;
    logic [31:0] e_v;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_rdy, input logic e_ena,
                            input logic [31:0] e_meth, input logic [31:0] e_v,
                            input logic [15:0] e_drop);
    chk({tag, ".enq_rdy"}, {31'b0, pipe_enq__RDY}, {31'b0, e_rdy});
    chk({tag, ".heard_ena"}, {31'b0, indication_heard__ENA}, {31'b0, e_ena});
    chk({tag, ".meth"}, indication_heard_meth, e_meth);
    chk({tag, ".v"}, indication_heard_v, e_v);
    chk({tag, ".drop"}, {16'b0, drop_count}, {16'b0, e_drop});
  endtask

  function automatic vec_t mk(logic rst, logic enq, logic [31:0] tag, logic [31:0] meth,
                              logic [31:0] v, logic hrdy, logic e_rdy, logic e_ena,
                              logic [31:0] e_meth, logic [31:0] e_v, logic [15:0] e_drop);
    vec_t r;
    r.rst = rst; r.enq = enq; r.tag = tag; r.meth = meth; r.v = v; r.hrdy = hrdy;
    r.e_rdy = e_rdy; r.e_ena = e_ena; r.e_meth = e_meth; r.e_v = e_v; r.e_drop = e_drop;
    return r;
  endfunction

  initial begin
    //             rst enq tag meth     v        hrdy rdy ena e_meth   e_v      drop
    vecs[0]  = mk(0, 1, 1, 32'h7,    32'h5,    1,   1,  0,  32'h0,   32'h0,   0);
    vecs[1]  = mk(0, 0, 0, 32'h0,    32'h0,    1,   1,  1,  32'h7,   32'h5,   0);
    vecs[2]  = mk(0, 0, 0, 32'h0,    32'h0,    1,   1,  0,  32'h0,   32'h0,   0);
    vecs[3]  = mk(0, 1, 1, 32'hA1,   32'hA2,   0,   1,  0,  32'h0,   32'h0,   0);
    vecs[4]  = mk(0, 1, 1, 32'hB1,   32'hB2,   0,   1,  1,  32'hA1,  32'hA2,  0);
    vecs[5]  = mk(0, 1, 1, 32'hC1,   32'hC2,   0,   0,  1,  32'hA1,  32'hA2,  0);
    vecs[6]  = mk(0, 1, 1, 32'hC1,   32'hC2,   1,   0,  1,  32'hA1,  32'hA2,  0);
    vecs[7]  = mk(0, 1, 1, 32'hC1,   32'hC2,   1,   1,  1,  32'hB1,  32'hB2,  0);
    vecs[8]  = mk(0, 0, 0, 32'h0,    32'h0,    1,   1,  1,  32'hC1,  32'hC2,  0);
    vecs[9]  = mk(0, 0, 0, 32'h0,    32'h0,    1,   1,  0,  32'h0,   32'h0,   0);
    vecs[10] = mk(0, 1, 2, 32'hDEAD, 32'hBEEF, 1,   1,  0,  32'h0,   32'h0,   0);
    vecs[11] = mk(0, 1, 1, 32'h9,    32'h99,   1,   1,  0,  32'h0,   32'h0,   1);
    vecs[12] = mk(0, 0, 0, 32'h0,    32'h0,    1,   1,  1,  32'h9,   32'h99,  1);
    vecs[13] = mk(0, 0, 0, 32'h0,    32'h0,    1,   1,  0,  32'h0,   32'h0,   1);
    vecs[14] = mk(0, 1, 1, 32'h11,   32'h12,   0,   1,  0,  32'h0,   32'h0,   1);
    vecs[15] = mk(0, 1, 1, 32'h21,   32'h22,   0,   1,  1,  32'h11,  32'h12,  1);
    vecs[16] = mk(1, 1, 1, 32'h31,   32'h32,   1,   0,  1,  32'h11,  32'h12,  1);
    vecs[17] = mk(0, 1, 3, 32'h0,    32'h0,    1,   1,  0,  32'h0,   32'h0,   0);
    vecs[18] = mk(0, 0, 0, 32'h0,    32'h0,    1,   1,  0,  32'h0,   32'h0,   1);

    RST = 1'b1; pipe_enq__ENA = 1'b0; pipe_enq_v = '0; indication_heard__RDY = 1'b1;
    s_ena = 1'b0; s_msg = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1 check_outs("reset", 1'b1, 1'b0, 32'h0, 32'h0, 16'h0);

    for (int unsigned i = 0; i < 19; i++) begin
      @(negedge CLK);
      RST = vecs[i].rst;
      pipe_enq__ENA = vecs[i].enq;
      pipe_enq_v = {vecs[i].v, vecs[i].meth, vecs[i].tag};
      indication_heard__RDY = vecs[i].hrdy;
      #1 check_outs($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_ena,
                    vecs[i].e_meth, vecs[i].e_v, vecs[i].e_drop);
    end

    for (int unsigned i = 0; i < 100; i++) begin
      @(negedge CLK);
      RST = 1'b0;
      pipe_enq__ENA = 1'b1;
      pipe_enq_v = {32'h1000 + 32'(i), 32'(i), 32'h1};
      indication_heard__RDY = 1'b1;
      #1;
      chk($sformatf("stream%0d.enq_rdy", i), {31'b0, pipe_enq__RDY}, 32'h1);
      if (i > 0) begin
        chk($sformatf("stream%0d.ena", i), {31'b0, indication_heard__ENA}, 32'h1);
        chk($sformatf("stream%0d.meth", i), indication_heard_meth, 32'(i - 1));
        chk($sformatf("stream%0d.v", i), indication_heard_v, 32'h1000 + 32'(i - 1));
      end
    end
    @(negedge CLK);
    pipe_enq__ENA = 1'b0;
    #1;
    chk("stream_last.ena", {31'b0, indication_heard__ENA}, 32'h1);
    chk("stream_last.meth", indication_heard_meth, 32'd99);
    @(negedge CLK);
    #1;
    chk("stream_drain.ena", {31'b0, indication_heard__ENA}, 32'h0);
    chk("stream_drain.drop", {16'b0, drop_count}, 32'h1);

    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge CLK);
      s_ena = (i < 5);
      s_msg = {32'h0, 32'h0, 32'h7};
      #1;
      chk($sformatf("sat%0d.drop", i), {30'b0, s_drop}, (i > 3) ? 32'd3 : 32'(i));
      chk($sformatf("sat%0d.ena", i), {31'b0, s_hena}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/echo_indication_input.md
ECHO_INDICATION_INPUT -- requirements
Module: echo_indication_input

Interface
REQ-001 SHALL have parameter HEARD_TAG, default 1, message tag value identifying a heard indication.
REQ-002 SHALL have parameter DROP_W, default 16, width of the dropped-message counter.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pipe$enq__ENA  input  1  upstream offers a message this cycle.
REQ-006 SHALL have port pipe$enq$v  input  96  message: [31:0] tag, [63:32] meth, [95:64] v.
REQ-007 SHALL have port pipe$enq__RDY  output  1  block can accept a message this cycle.
REQ-008 SHALL have port indication$heard__ENA  output  1  decoded heard call valid.
REQ-009 SHALL have port indication$heard$meth  output  32  decoded meth field.
REQ-010 SHALL have port indication$heard$v  output  32  decoded v field.
REQ-011 SHALL have port indication$heard__RDY  input  1  downstream accepts the call this cycle.
REQ-012 SHALL have port drop_count  output  DROP_W  count of messages discarded for unknown tag.

Function
REQ-013 SHALL hold a two-entry ping-pong buffer (entry0, entry1), each with full flag, meth and v registers.
REQ-014 SHALL keep 1-bit write pointer wsel and read pointer rsel; each toggles only on a completed transfer on its side.
REQ-015 SHALL drive pipe$enq__RDY = !full[wsel], combinationally from registered state only.
REQ-016 SHALL treat an enqueue as taken only when pipe$enq__ENA & pipe$enq__RDY; ENA with RDY low is ignored, no state change.
REQ-017 On taken enqueue with tag == HEARD_TAG SHALL write meth/v into entry[wsel], set full[wsel], toggle wsel.
REQ-018 On taken enqueue with tag != HEARD_TAG SHALL store nothing, leave wsel unchanged, increment drop_count.
REQ-019 drop_count SHALL saturate at all-ones, never wrap.
REQ-020 SHALL drive indication$heard__ENA = full[rsel]; meth/v outputs = entry[rsel] fields when ENA high, else 0.
REQ-021 On indication$heard__ENA & indication$heard__RDY SHALL clear full[rsel] and toggle rsel.
REQ-022 Latency SHALL be exactly one cycle: message taken in cycle N appears on indication$heard__ENA in cycle N+1 if no older entry pending.
REQ-023 Simultaneous enqueue and dequeue in one cycle SHALL both complete; sustained throughput SHALL be one message per cycle.
REQ-024 When both entries full, pipe$enq__RDY SHALL be 0 until a dequeue completes; RDY rises the cycle after that dequeue.
REQ-025 Delivery order SHALL equal acceptance order of heard messages; dropped messages SHALL not create gaps or stalls.
REQ-026 indication$heard__RDY high while ENA low SHALL have no effect.
REQ-027 Output data SHALL remain stable while ENA high and RDY low.

Reset
REQ-028 While RST high at a clock edge SHALL clear both full flags, entry data, wsel, rsel, drop_count to 0.
REQ-029 During and after reset cycle: pipe$enq__RDY = 1, indication$heard__ENA = 0, meth/v = 0, drop_count = 0.
REQ-030 Reset mid-operation SHALL discard buffered, undelivered messages; no call issued for them after reset.
REQ-031 Enqueue or dequeue handshakes in a cycle with RST high SHALL be ignored.

Verification
REQ-032 Single message: enq v={32'h5,32'h7,32'h1}, heard RDY=1 -> next cycle ENA=1, meth=7, v=5; following cycle ENA=0.
REQ-033 Backpressure: heard RDY=0, enq tag-1 messages A,B,C back-to-back -> A,B accepted, RDY=0 on C; raise heard RDY -> A then B delivered, C accepted cycle after A dequeued, order A,B,C.
REQ-034 Unknown tag: enq tag=2, then tag=1 meth=9 -> drop_count=1, only one call with meth=9, no bubble.
REQ-035 Streaming: 100 tag-1 messages every cycle, heard RDY=1 -> pipe$enq__RDY never 0, 100 calls in order, one per cycle.
REQ-036 Saturation: DROP_W=2, enq 5 bad-tag messages -> drop_count=3 and holds.
REQ-037 Reset mid-operation: two buffered messages, RST high one cycle -> ENA=0, RDY=1, drop_count=0; neither message delivered.
